// File: rtl/interrupt_gen.sv
// interrupt_gen
//   Machine-mode interrupt source for the RV32I core. It contains a 64-bit
//   mtime/mtimecmp timer, the msip software-interrupt bit and the external
//   IRQ input. Pending sources are arbitrated against the mie enables and
//   mstatus.MIE. A take is issued to csr_array as a one-cycle g_interrupt
//   pulse. The block then stays masked until mret executes.
//
// Parameters
//   TIMER_DIV        clk cycles per mtime increment (1..65535)
//
// Build option
//   IRQ_EXT_SYNC_EN  when defined, ext_irq passes through a 2-flop
//                    synchronizer, which adds 2 cycles of latency. When it
//                    is undefined, ext_irq must be synchronous to clk.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   io_we, io_re        one-cycle IO write / read strobes
//   io_adr              word offset: 0 msip, 1 cmp_lo, 2 cmp_hi,
//                       3 time_lo, 4 time_hi
//   io_wdata            write data
//   io_rdata            registered read data, valid the cycle after io_re
//   ext_irq             external interrupt request, level-high
//   csr_meie/mtie/msie  mie enables
//   csr_mstatus_mie     global interrupt enable
//   cmd_mret_ex         mret executing in EX, releases the handler state
//   stall               pipeline stall; blocks issuing a take
//   g_interrupt         one-cycle interrupt-take pulse
//   g_interrupt_priv    target privilege, always M (2'b11)
//   irq_cause           cause of the last take (11 ext, 3 soft, 7 timer)
//
// state   | meaning
// IDLE    | waiting for an enabled pending source
// TAKE    | g_interrupt asserted for this single cycle
// HANDLER | handler running, all sources masked until mret
module interrupt_gen #(
  parameter int unsigned TIMER_DIV = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_we,
  input  logic        io_re,
  input  logic [2:0]  io_adr,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  input  logic        ext_irq,
  input  logic        csr_meie,
  input  logic        csr_mtie,
  input  logic        csr_msie,
  input  logic        csr_mstatus_mie,
  input  logic        cmd_mret_ex,
  input  logic        stall,
  output logic        g_interrupt,
  output logic [1:0]  g_interrupt_priv,
  output logic [3:0]  irq_cause
);

  localparam logic [15:0] PRESC_MAX = 16'(TIMER_DIV - 1);

  typedef enum logic [1:0] {IDLE, TAKE, HANDLER} state_t;

  state_t      state, state_nxt;
  logic        load_cause;
  logic [3:0]  cause_nxt;
  logic [15:0] prescaler;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;
  logic        ext_irq_s;
  logic        time_tick;
  logic        wr_time_lo, wr_time_hi;
  logic        mtip, meip, msip_p, mtip_p, any_pending;
  logic [31:0] rd_mux;

`ifdef IRQ_EXT_SYNC_EN
  logic [1:0] ext_sync;

  always_ff @(posedge clk) begin
    if (rst) ext_sync <= 2'b00;
    else     ext_sync <= {ext_sync[0], ext_irq};
  end

  assign ext_irq_s = ext_sync[1];
`else
  assign ext_irq_s = ext_irq;
`endif

  assign wr_time_lo = io_we && (io_adr == 3'd3);
  assign wr_time_hi = io_we && (io_adr == 3'd4);
  assign time_tick  = (prescaler == PRESC_MAX);

  // A time write discards the increment from the same cycle, including any
  // carry into the other half. The write also restarts the prescale period.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      mtime     <= '0;
    end else begin
      if (wr_time_lo || wr_time_hi || time_tick) prescaler <= '0;
      else                                       prescaler <= prescaler + 16'd1;

      if (wr_time_lo)      mtime <= {mtime[63:32], io_wdata};
      else if (wr_time_hi) mtime <= {io_wdata, mtime[31:0]};
      else if (time_tick)  mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtimecmp <= '1;
      msip     <= 1'b0;
    end else if (io_we) begin
      case (io_adr)
        3'd0:    msip           <= io_wdata[0];
        3'd1:    mtimecmp[31:0]  <= io_wdata;
        3'd2:    mtimecmp[63:32] <= io_wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (io_adr)
      3'd0:    rd_mux = {31'd0, msip};
      3'd1:    rd_mux = mtimecmp[31:0];
      3'd2:    rd_mux = mtimecmp[63:32];
      3'd3:    rd_mux = mtime[31:0];
      3'd4:    rd_mux = mtime[63:32];
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)        io_rdata <= '0;
    else if (io_re) io_rdata <= rd_mux;
  end

  assign mtip        = (mtime >= mtimecmp);
  assign meip        = ext_irq_s & csr_meie;
  assign msip_p      = msip & csr_msie;
  assign mtip_p      = mtip & csr_mtie;
  assign any_pending = meip | msip_p | mtip_p;

  always_comb begin
    cause_nxt = 4'd7;
    if (meip)        cause_nxt = 4'd11;
    else if (msip_p) cause_nxt = 4'd3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      irq_cause <= '0;
    end else begin
      state <= state_nxt;
      if (load_cause) irq_cause <= cause_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    load_cause = 1'b0;
    case (state)
      IDLE: begin
        if (any_pending && csr_mstatus_mie && !stall) begin
          state_nxt  = TAKE;
          load_cause = 1'b1;
        end
      end
      TAKE:    state_nxt = HANDLER;
      HANDLER: if (cmd_mret_ex) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign g_interrupt      = (state == TAKE);
  assign g_interrupt_priv = 2'b11;

endmodule

// File: tb/tb_interrupt_gen.sv
// tb_interrupt_gen
//   Scoreboard bench for interrupt_gen. A reference model runs on every rising
//   edge. It pushes the expected read data and the expected interrupt causes
//   into queues. A monitor runs on the falling edge. It pops those queues and
//   compares them against the DUT outputs. The model keeps mtime as a written
//   base value plus elapsed cycles divided by the prescale ratio.
`timescale 1ns/1ps
module tb_interrupt_gen;

  localparam int DIV = 4;
  localparam int P_IDLE = 0, P_TAKE = 1, P_HDL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        io_we = 1'b0, io_re = 1'b0;
  logic [2:0]  io_adr = '0;
  logic [31:0] io_wdata = '0;
  logic [31:0] io_rdata;
  logic        ext_irq = 1'b0;
  logic        csr_meie = 1'b0, csr_mtie = 1'b0, csr_msie = 1'b0;
  logic        csr_mstatus_mie = 1'b0;
  logic        cmd_mret_ex = 1'b0;
  logic        stall = 1'b0;
  logic        g_interrupt;
  logic [1:0]  g_interrupt_priv;
  logic [3:0]  irq_cause;

  always #5 clk = ~clk;

  interrupt_gen #(.TIMER_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .io_we(io_we), .io_re(io_re), .io_adr(io_adr),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .ext_irq(ext_irq),
    .csr_meie(csr_meie), .csr_mtie(csr_mtie), .csr_msie(csr_msie),
    .csr_mstatus_mie(csr_mstatus_mie), .cmd_mret_ex(cmd_mret_ex),
    .stall(stall), .g_interrupt(g_interrupt),
    .g_interrupt_priv(g_interrupt_priv), .irq_cause(irq_cause)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] cyc = '0;
  logic [63:0] m_base = '0, m_wr = '0, m_cmp = '1;
  logic        m_msip = 1'b0;
  logic [31:0] m_rdata = '0;
  logic [3:0]  m_cause = '0;
  int          m_phase = P_IDLE;
  logic        rd_due = 1'b0;
  logic [1:0]  m_ext_d = '0;
  logic [31:0] rd_q[$];
  logic [3:0]  irq_q[$];

  function automatic logic [63:0] model_time();
    return m_base + ((cyc - m_wr - 64'd1) / 64'(DIV));
  endfunction

  always @(posedge clk) begin
    logic [63:0] t;
    logic        ext_s, meip, msp, mtp;
    logic [3:0]  c;
    logic [31:0] rv;
    cyc++;
    if (rst) begin
      m_base = '0; m_wr = cyc; m_cmp = '1; m_msip = 1'b0;
      m_rdata = '0; m_cause = '0; m_phase = P_IDLE; rd_due = 1'b0;
      m_ext_d = '0;
    end else begin
      t = model_time();
`ifdef IRQ_EXT_SYNC_EN
      ext_s = m_ext_d[1];
      m_ext_d = {m_ext_d[0], ext_irq};
`else
      ext_s = ext_irq;
`endif
      meip = ext_s && csr_meie;
      msp  = m_msip && csr_msie;
      mtp  = (t >= m_cmp) && csr_mtie;
      c = meip ? 4'd11 : (msp ? 4'd3 : 4'd7);

      rd_due = io_re;
      if (io_re) begin
        case (io_adr)
          3'd0: rv = {31'd0, m_msip};
          3'd1: rv = m_cmp[31:0];
          3'd2: rv = m_cmp[63:32];
          3'd3: rv = t[31:0];
          3'd4: rv = t[63:32];
          default: rv = '0;
        endcase
        rd_q.push_back(rv);
        m_rdata = rv;
      end

      if (m_phase == P_IDLE) begin
        if ((meip || msp || mtp) && csr_mstatus_mie && !stall) begin
          m_phase = P_TAKE;
          m_cause = c;
          irq_q.push_back(c);
        end
      end else if (m_phase == P_TAKE) begin
        m_phase = P_HDL;
      end else if (cmd_mret_ex) begin
        m_phase = P_IDLE;
      end

      if (io_we) begin
        case (io_adr)
          3'd0: m_msip = io_wdata[0];
          3'd1: m_cmp[31:0] = io_wdata;
          3'd2: m_cmp[63:32] = io_wdata;
          3'd3: begin m_base = {t[63:32], io_wdata}; m_wr = cyc; end
          3'd4: begin m_base = {io_wdata, t[31:0]}; m_wr = cyc; end
          default: ;
        endcase
      end
    end
  end

  // ---------------- monitor ----------------
  logic [63:0] pulse_cyc = '0;

  always @(negedge clk) begin
    logic [31:0] er;
    logic [3:0]  ec;
    if (rd_due) begin
      if (rd_q.size() == 0) chk("read_queue_empty", 64'd0, 64'd1);
      else begin
        er = rd_q.pop_front();
        chk("io_rdata", io_rdata, er);
      end
    end else begin
      chk("io_rdata_hold", io_rdata, m_rdata);
    end

    if (g_interrupt) pulse_cyc = cyc;
    if (g_interrupt || m_phase == P_TAKE) begin
      chk("g_interrupt", g_interrupt, m_phase == P_TAKE);
      if (m_phase == P_TAKE && irq_q.size() != 0) begin
        ec = irq_q.pop_front();
        chk("irq_cause", irq_cause, ec);
        chk("g_interrupt_priv", g_interrupt_priv, 2'b11);
      end
    end else begin
      chk("irq_cause_hold", irq_cause, m_cause);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    io_we = 1'b1; io_adr = a; io_wdata = d;
    tick();
    io_we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a);
    io_re = 1'b1; io_adr = a;
    tick();
    io_re = 1'b0;
  endtask

  task automatic mret();
    cmd_mret_ex = 1'b1;
    tick();
    cmd_mret_ex = 1'b0;
  endtask

  initial begin
    logic [63:0] rel;

    // Reset state read back
    repeat (3) tick();
    rst = 1'b0;
    for (int a = 0; a < 5; a++) rd(3'(a));
    tick();

    // Timer interrupt at mtime == 5, then a retake after mret while still pending
    rst = 1'b1; csr_mtie = 1'b1; csr_mstatus_mie = 1'b1;
    tick();
    rst = 1'b0;
    rel = cyc;
    wr(3'd2, 32'd0);
    wr(3'd1, 32'd5);
    repeat (30) tick();
    chk("timer_take_latency", pulse_cyc - rel, 64'd21);
    repeat (10) tick();
    mret();
    repeat (4) tick();
    csr_mtie = 1'b0;
    mret();
    repeat (3) tick();

    // External and software interrupts raised in the same cycle
    csr_meie = 1'b1; csr_msie = 1'b1; ext_irq = 1'b1;
    wr(3'd0, 32'd1);
    repeat (5) tick();
    ext_irq = 1'b0;
    repeat (3) tick();
    mret();
    repeat (4) tick();
    wr(3'd0, 32'd0);
    mret();
    repeat (3) tick();

    // Stall blocks a pending source for 10 cycles
    stall = 1'b1;
    wr(3'd0, 32'd1);
    repeat (9) tick();
    stall = 1'b0;
    repeat (4) tick();
    wr(3'd0, 32'd0);
    mret();
    repeat (3) tick();

    // mtime wrap, and time writes landing on increment cycles
    wr(3'd3, 32'hFFFF_FFFF);
    wr(3'd4, 32'hFFFF_FFFF);
    repeat (DIV) tick();
    rd(3'd3); rd(3'd4);
    wr(3'd3, 32'h1234_0000);
    repeat (DIV - 1) tick();
    wr(3'd3, 32'h0000_0100);
    rd(3'd3); rd(3'd4);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, DIV - 1)) tick();
      wr(3'($urandom_range(3, 4)), $urandom());
      rd(3'd3); rd(3'd4);
    end

    // Reset while in the handler
    wr(3'd0, 32'd1);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd(3'd0); rd(3'd1);
    repeat (3) tick();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 199) == 0);
      io_we       = ($urandom_range(0, 5) == 0);
      io_re       = ($urandom_range(0, 3) == 0);
      io_adr      = 3'($urandom_range(0, 7));
      io_wdata    = $urandom_range(0, 1) ? 32'($urandom_range(0, 40)) : $urandom();
      if ($urandom_range(0, 15) == 0) ext_irq = ~ext_irq;
      if ($urandom_range(0, 31) == 0) csr_meie = ~csr_meie;
      if ($urandom_range(0, 31) == 0) csr_mtie = ~csr_mtie;
      if ($urandom_range(0, 31) == 0) csr_msie = ~csr_msie;
      if ($urandom_range(0, 31) == 0) csr_mstatus_mie = ~csr_mstatus_mie;
      stall       = ($urandom_range(0, 3) == 0);
      cmd_mret_ex = ($urandom_range(0, 6) == 0);
      tick();
    end
    rst = 1'b0; io_we = 1'b0; io_re = 1'b0; cmd_mret_ex = 1'b0; stall = 1'b0;
    repeat (3) tick();

    chk("scoreboard_drained", 64'(rd_q.size() + irq_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
